// File: rtl/z_divider.sv
// Sequential complex divider Q = A / B in signed Q1.14, using restoring division at one bit per cycle.
// The real and imaginary quotients share a single divisor D = Br^2 + Bi^2 and are computed in lock-step.
module z_divider #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC       = 14
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] Ar,
    input  logic signed [DATA_WIDTH-1:0] Ai,
    input  logic signed [DATA_WIDTH-1:0] Br,
    input  logic signed [DATA_WIDTH-1:0] Bi,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] Rout,
    output logic signed [DATA_WIDTH-1:0] Iout,
    output logic                         ovf,
    output logic                         div_zero
);

    localparam int DW = DATA_WIDTH;
    localparam int PW = 2 * DW;            // product width
    localparam int NW = 2 * DW + 1;        // numerator sum width
    localparam int SH = DW - 2 - FRAC;     // divisor pre-shift that aligns the quotient MSB
    localparam int RW = 3 * DW - FRAC;     // partial remainder width, holds up to 2*(D << SH)
    localparam int CW = $clog2(DW);
    localparam logic [CW-1:0] LAST = CW'(DW - 2);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]           state;
    logic                 ph;
    logic signed [DW-1:0] ar, ai, br, bi;
    logic signed [PW-1:0] p_rr, p_ii, p_ir, p_ri, p_bb, p_cc;
    logic [RW-1:0]        rr, ri, ds;
    logic [DW-2:0]        qr, qi;
    logic                 sr, si, satr, sati;
    logic [CW-1:0]        cnt;

    logic signed [NW-1:0] nr_c, ni_c;
    logic [NW-1:0]        nr_mag, ni_mag;
    logic [PW-1:0]        d_c;
    logic [RW-1:0]        ds_c;
    logic                 satr_c, sati_c;
    logic                 ger, gei;
    logic [RW-1:0]        rr_nx, ri_nx;
    logic [DW-2:0]        qr_nx, qi_nx;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    function automatic logic [DW-1:0] fmt(input logic neg, input logic sat, input logic [DW-2:0] q);
        if (sat)
            return neg ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        return neg ? -{1'b0, q} : {1'b0, q};
    endfunction

    // Full-precision numerators and divisor from the registered products.
    always_comb begin
        nr_c   = {p_rr[PW-1], p_rr} + {p_ii[PW-1], p_ii};
        ni_c   = {p_ir[PW-1], p_ir} - {p_ri[PW-1], p_ri};
        nr_mag = nr_c[NW-1] ? -nr_c : nr_c;
        ni_mag = ni_c[NW-1] ? -ni_c : ni_c;
        d_c    = $unsigned(p_bb) + $unsigned(p_cc);
        ds_c   = RW'(d_c) << SH;
        satr_c = RW'(nr_mag) >= (ds_c << 1);
        sati_c = RW'(ni_mag) >= (ds_c << 1);
    end

    // One restoring step per component: subtract if it fits, record the bit, shift.
    always_comb begin
        ger   = rr >= ds;
        gei   = ri >= ds;
        rr_nx = (ger ? rr - ds : rr) << 1;
        ri_nx = (gei ? ri - ds : ri) << 1;
        qr_nx = {qr[DW-3:0], ger};
        qi_nx = {qi[DW-3:0], gei};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ph       <= 1'b0;
            ar       <= '0;
            ai       <= '0;
            br       <= '0;
            bi       <= '0;
            p_rr     <= '0;
            p_ii     <= '0;
            p_ir     <= '0;
            p_ri     <= '0;
            p_bb     <= '0;
            p_cc     <= '0;
            rr       <= '0;
            ri       <= '0;
            ds       <= '0;
            qr       <= '0;
            qi       <= '0;
            sr       <= 1'b0;
            si       <= 1'b0;
            satr     <= 1'b0;
            sati     <= 1'b0;
            cnt      <= '0;
            Rout     <= '0;
            Iout     <= '0;
            ovf      <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ar    <= Ar;
                        ai    <= Ai;
                        br    <= Br;
                        bi    <= Bi;
                        ph    <= 1'b0;
                        state <= CALC;
                    end
                end
                // CALC spends two cycles: products are registered first, then sums and decisions.
                CALC: begin
                    if (!ph) begin
                        p_rr <= PW'(ar) * PW'(br);
                        p_ii <= PW'(ai) * PW'(bi);
                        p_ir <= PW'(ai) * PW'(br);
                        p_ri <= PW'(ar) * PW'(bi);
                        p_bb <= PW'(br) * PW'(br);
                        p_cc <= PW'(bi) * PW'(bi);
                        ph   <= 1'b1;
                    end else begin
                        ph <= 1'b0;
                        if (d_c == '0) begin
                            Rout     <= '0;
                            Iout     <= '0;
                            ovf      <= 1'b0;
                            div_zero <= 1'b1;
                            state    <= DONE;
                        end else begin
                            rr    <= RW'(nr_mag);
                            ri    <= RW'(ni_mag);
                            ds    <= ds_c;
                            sr    <= nr_c[NW-1];
                            si    <= ni_c[NW-1];
                            satr  <= satr_c;
                            sati  <= sati_c;
                            qr    <= '0;
                            qi    <= '0;
                            cnt   <= '0;
                            state <= DIV;
                        end
                    end
                end
                DIV: begin
                    rr  <= rr_nx;
                    ri  <= ri_nx;
                    qr  <= qr_nx;
                    qi  <= qi_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        Rout     <= fmt(sr, satr, qr_nx);
                        Iout     <= fmt(si, sati, qi_nx);
                        ovf      <= satr | sati;
                        div_zero <= 1'b0;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_z_divider.sv
// Directed self-checking bench for z_divider: quotient values, flags, latency and handshake behaviour.
module tb_z_divider;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] Ar, Ai, Br, Bi;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] Rout, Iout;
    logic               ovf;
    logic               div_zero;

    int n_checks = 0;
    int n_fail   = 0;
    int lat      = 0;

    z_divider #(.DATA_WIDTH(16), .FRAC(14)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .Ar(Ar), .Ai(Ai), .Br(Br), .Bi(Bi),
        .out_valid(out_valid), .out_ready(out_ready),
        .Rout(Rout), .Iout(Iout), .ovf(ovf), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        lat++;
    endtask

    // Present operands in IDLE; the accept edge is the next rising edge.
    task automatic accept(input logic signed [15:0] ar, ai, br, bi);
        Ar = ar; Ai = ai; Br = br; Bi = bi;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        lat = 0;
        in_valid = 1'b0;
        Ar = 16'($urandom); Ai = 16'($urandom); Br = 16'($urandom); Bi = 16'($urandom);
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        while (!out_valid && lat < 40) tick();
        check({tag, "_latency"}, lat, exp_lat);
    endtask

    task automatic check_result(input string tag, input logic signed [15:0] er, ei,
                                input logic eo, ez);
        check({tag, "_valid"}, {31'd0, out_valid}, 1);
        check({tag, "_Rout"}, Rout, er);
        check({tag, "_Iout"}, Iout, ei);
        check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
        check({tag, "_divzero"}, {31'd0, div_zero}, {31'd0, ez});
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_drop_valid"}, {31'd0, out_valid}, 0);
        check({tag, "_ready_back"}, {31'd0, in_ready}, 1);
    endtask

    task automatic run_op(input string tag, input logic signed [15:0] ar, ai, br, bi,
                          input logic signed [15:0] er, ei, input logic eo, ez, input int el);
        accept(ar, ai, br, bi);
        wait_done(tag, el);
        check_result(tag, er, ei, eo, ez);
        release_out(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        Ar = '0; Ai = '0; Br = '0; Bi = '0;
        repeat (3) tick();
        check("rst_in_ready", {31'd0, in_ready}, 1);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_Rout", Rout, 0);
        check("rst_Iout", Iout, 0);
        check("rst_ovf", {31'd0, ovf}, 0);
        check("rst_divzero", {31'd0, div_zero}, 0);
        rst = 1'b0;

        // out_ready with nothing pending changes nothing
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_ready_ignored", {31'd0, in_ready, out_valid}, 2);

        // T1..T4 basic quotients, saturation, truncation and divide-by-zero
        run_op("t1", 16'sh2000, 16'sd0, 16'sh4000, 16'sd0, 16'sd8192, 16'sd0, 1'b0, 1'b0, 17);
        run_op("t2", 16'sd0, 16'sd16384, 16'sd8192, 16'sd8192, 16'sd16384, 16'sd16384, 1'b0, 1'b0, 17);
        run_op("t3a", 16'sd0, -16'sd8192, 16'sd0, -16'sd16384, 16'sd8192, 16'sd0, 1'b0, 1'b0, 17);
        run_op("t3b", 16'sh399A, 16'sh399A, 16'sh399A, 16'sh399A, 16'sd16384, 16'sd0, 1'b0, 1'b0, 17);
        run_op("t4pos", 16'sd16384, 16'sd0, 16'sd4096, 16'sd0, 16'sd32767, 16'sd0, 1'b1, 1'b0, 17);
        run_op("t4neg", -16'sd16384, 16'sd0, 16'sd4096, 16'sd0, -16'sd32768, 16'sd0, 1'b1, 1'b0, 17);
        run_op("exact_m2", -16'sd8192, 16'sd0, 16'sd4096, 16'sd0, -16'sd32768, 16'sd0, 1'b1, 1'b0, 17);
        run_op("below_sat", 16'sd16383, 16'sd0, 16'sd8192, 16'sd0, 16'sd32766, 16'sd0, 1'b0, 1'b0, 17);
        run_op("trunc", -16'sd1, 16'sd1, 16'sd3, 16'sd0, -16'sd5461, 16'sd5461, 1'b0, 1'b0, 17);
        run_op("zero_num", 16'sd0, 16'sd0, 16'sd1234, -16'sd77, 16'sd0, 16'sd0, 1'b0, 1'b0, 17);
        run_op("divzero", 16'sd5000, -16'sd300, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b0, 1'b1, 2);

        // T5 stalls in DIV are ignored; DONE holds until out_ready
        accept(16'sd0, 16'sd16384, 16'sd8192, 16'sd8192);
        repeat (5) tick();
        check("t5_busy_ready", {31'd0, in_ready}, 0);
        Ar = 16'sd16384; Ai = 16'sd0; Br = 16'sd4096; Bi = 16'sd0;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        wait_done("t5", 17);
        check_result("t5", 16'sd16384, 16'sd16384, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t5_hold", {15'd0, out_valid, in_ready, Rout}, {15'd0, 1'b1, 1'b0, 16'sd16384});
            check("t5_hold_Iout", Iout, 16'sd16384);
        end
        release_out("t5");

        // T6 reset during DIV aborts the operation
        accept(16'sh2000, 16'sd0, 16'sh4000, 16'sd0);
        while (lat < 7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_out_valid", {31'd0, out_valid}, 0);
        check("t6_in_ready", {31'd0, in_ready}, 1);
        check("t6_Rout", Rout, 0);
        check("t6_Iout", Iout, 0);
        repeat (20) tick();
        check("t6_no_result", {31'd0, out_valid}, 0);
        run_op("t6_t1", 16'sh2000, 16'sd0, 16'sh4000, 16'sd0, 16'sd8192, 16'sd0, 1'b0, 1'b0, 17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
